// File: rtl/model_matrix_transmitter.sv
// model_matrix_transmitter: streams a row-major matrix from synchronous memory, one element per consumer request
module model_matrix_transmitter #(
   parameter int DATA_SIZE    = 64,
   parameter int ADDRESS_SIZE = 12
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    START,
   output logic                    READY,
   input  logic [DATA_SIZE-1:0]    SIZE_I_IN,
   input  logic [DATA_SIZE-1:0]    SIZE_J_IN,
   input  logic [ADDRESS_SIZE-1:0] BASE_ADDRESS,
   output logic [ADDRESS_SIZE-1:0] MEM_ADDRESS,
   output logic                    MEM_READ,
   input  logic [DATA_SIZE-1:0]    MEM_DATA,
   output logic [DATA_SIZE-1:0]    DATA_OUT,
   output logic                    DATA_I_ENABLE,
   output logic                    DATA_J_ENABLE,
   input  logic                    DATA_I_REQUEST,
   input  logic                    DATA_J_REQUEST
);
   typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;
   state_t state, state_nxt;
   logic [DATA_SIZE-1:0] size_i, size_j, i, j;
   logic [ADDRESS_SIZE-1:0] addr;
   logic accept, empty, j_last, i_last, adv_j, adv_i, done;
   // START is refused while READY is still pulsing from the previous transfer
   assign accept = state == IDLE && START && !READY;
   assign empty  = SIZE_I_IN == '0 || SIZE_J_IN == '0;
   assign j_last = j == size_j - DATA_SIZE'(1);
   assign i_last = i == size_i - DATA_SIZE'(1);
   assign adv_j  = state == HOLD && !j_last && DATA_J_REQUEST;
   assign adv_i  = state == HOLD && j_last && !i_last && DATA_I_REQUEST;
   assign done   = state == HOLD && j_last && i_last && (DATA_I_REQUEST || DATA_J_REQUEST);
   assign MEM_READ    = state == FETCH;
   assign MEM_ADDRESS = MEM_READ ? addr : '0;
   // state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end
   // next-state: one read per element, then park in HOLD until the consumer asks for more
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = (accept && !empty) ? FETCH : IDLE;
         FETCH:   state_nxt = WAIT;
         WAIT:    state_nxt = HOLD;
         HOLD:    state_nxt = (adv_j || adv_i) ? FETCH : done ? IDLE : HOLD;
         default: state_nxt = IDLE;
      endcase
   end
   // position counters, address, presented element and the one-cycle strobes
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         size_i        <= '0;
         size_j        <= '0;
         i             <= '0;
         j             <= '0;
         addr          <= '0;
         DATA_OUT      <= '0;
         DATA_I_ENABLE <= 1'b0;
         DATA_J_ENABLE <= 1'b0;
         READY         <= 1'b0;
      end else begin
         if (accept) begin
            size_i <= SIZE_I_IN;
            size_j <= SIZE_J_IN;
            addr   <= BASE_ADDRESS;
            i      <= '0;
            j      <= '0;
         end
         if (adv_j) begin
            j    <= j + DATA_SIZE'(1);
            addr <= addr + ADDRESS_SIZE'(1);
         end
         if (adv_i) begin
            i    <= i + DATA_SIZE'(1);
            j    <= '0;
            addr <= addr + ADDRESS_SIZE'(1);
         end
         if (state == WAIT) DATA_OUT <= MEM_DATA;
         DATA_J_ENABLE <= state == WAIT;
         DATA_I_ENABLE <= state == WAIT && j == '0;
         READY         <= (accept && empty) || done;
      end
   end
endmodule

// File: doc/model_matrix_transmitter.md
Name: model_matrix_transmitter

Overview:
- Request-driven transmitter for the two-level (row/element) matrix streaming protocol used by the model controller's *_IN / *_OUT_*_ENABLE ports.
- Fetches a SIZE_I_IN x SIZE_J_IN row-major matrix from a synchronous memory and presents it one element at a time.
- Advances only when the consumer pulses its element or row request.
- Drives W_IN/K_IN/U_IN-style inputs of a consumer, replacing hand-written stimulus sequences.

Parameters:
DATA_SIZE, 64, width of data words and size operands
ADDRESS_SIZE, 12, width of memory address

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  asynchronous active-high reset
START  input  1  one-cycle pulse; begin transfer (sampled only in IDLE)
READY  output  1  one-cycle pulse; transfer complete
SIZE_I_IN  input  DATA_SIZE  number of rows, latched on accepted START
SIZE_J_IN  input  DATA_SIZE  elements per row, latched on accepted START
BASE_ADDRESS  input  ADDRESS_SIZE  address of element (0,0), latched on accepted START
MEM_ADDRESS  output  ADDRESS_SIZE  memory read address
MEM_READ  output  1  memory read strobe; MEM_DATA valid exactly one cycle later
MEM_DATA  input  DATA_SIZE  memory read data
DATA_OUT  output  DATA_SIZE  current element, held stable until next element is presented
DATA_I_ENABLE  output  1  one-cycle pulse with first element of each row
DATA_J_ENABLE  output  1  one-cycle pulse with every element
DATA_I_REQUEST  input  1  consumer pulse: advance to next row
DATA_J_REQUEST  input  1  consumer pulse: advance to next element in row

Behaviour:
- Reset: state IDLE. READY, MEM_READ, DATA_I_ENABLE, DATA_J_ENABLE = 0. MEM_ADDRESS, DATA_OUT = 0. Counters i, j = 0. Reset mid-transfer aborts immediately and produces no READY.
- States: IDLE, FETCH, WAIT, HOLD.
- IDLE:
  - START accepted: latch sizes and BASE_ADDRESS; address register <= BASE_ADDRESS; i = j = 0.
  - If SIZE_I_IN = 0 or SIZE_J_IN = 0: pulse READY next cycle, stay in IDLE.
  - Otherwise go to FETCH.
- FETCH (1 cycle): MEM_READ = 1, MEM_ADDRESS = address register. Go to WAIT.
- WAIT (1 cycle): at the closing edge, DATA_OUT <= MEM_DATA, DATA_J_ENABLE <= 1, and DATA_I_ENABLE <= (j == 0). Go to HOLD.
- HOLD: enables high in the first HOLD cycle only. A request is accepted in any HOLD cycle, including the first.
  - j < SIZE_J-1 and DATA_J_REQUEST: j++, address+1, go to FETCH.
  - j = SIZE_J-1 and i < SIZE_I-1 and DATA_I_REQUEST: i++, j = 0, address+1, go to FETCH.
  - Last element (i = SIZE_I-1, j = SIZE_J-1) and either request: READY pulse next cycle, go to IDLE.
  - Any other request is ignored; stay in HOLD. If both requests are high, the one valid for the position wins.
- Latency:
  - START (cycle 0) -> MEM_READ cycle 1 -> DATA_J_ENABLE cycle 3.
  - Accepted request in cycle k -> MEM_READ cycle k+1 -> enables cycle k+3.
  - Last request in cycle k -> READY cycle k+1.
- Addresses increment modulo 2^ADDRESS_SIZE: wrap from all-ones to 0 without error.
- START outside IDLE is ignored. START in the same cycle READY pulses is not accepted; START is accepted from the cycle after READY.
- i and j are DATA_SIZE wide; comparisons are unsigned.

Test Plan:
- 2x3 matrix at BASE 0x010 holding 10..15, each request issued 2 cycles after DATA_J_ENABLE:
  - reads 0x010..0x015 in order; DATA_OUT sequence 10,11,12,13,14,15;
  - DATA_I_ENABLE only with 10 and 13;
  - READY one cycle after the final request.
- SIZE_I_IN = 0 or SIZE_J_IN = 0 with START -> READY pulse in cycle 1; MEM_READ never asserted; outputs stay 0.
- 1x2 matrix, DATA_I_REQUEST issued at j=0 -> ignored, no MEM_READ. Then DATA_J_REQUEST -> second element presented. Both requests high at row end of a 2x1 matrix -> advances to row 1.
- BASE 0xFFE, 1x4 matrix -> MEM_ADDRESS sequence 0xFFE, 0xFFF, 0x000, 0x001.
- RST asserted in HOLD after the 2nd element of a 2x2 transfer:
  - all outputs 0 immediately, no READY;
  - a new START after RST release restarts at BASE_ADDRESS.
- START pulsed during WAIT/HOLD -> no effect on sizes, address or sequence. Request issued in the same cycle as DATA_J_ENABLE -> MEM_READ the next cycle.
